dbus_mem_responder: RTL

Memory-side responder for the vector unit's wide data bus (dbus). It accepts single-word read and write requests from a dbus initiator such as the vector DMA engine. It services them from an internal word-addressed array with fixed, parameterised latency, and signals completion with `dbus_wait` and `dbus_data_valid`. It is the slave end of the dbus protocol, used as the vector data memory and as the bench memory model.

---
 rtl/dbus_mem_responder_if.sv | 29 ++
 rtl/dbus_mem_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dbus_mem_responder_if.sv
// Wide data bus (dbus) between an initiator (master) and a memory responder (slave).
// Handshake: the master pulses dbus_en for one cycle while dbus_wait is low; the slave raises
// dbus_wait while servicing, and for reads pulses dbus_data_valid with dbus_readdata in the
// cycle dbus_wait falls. A dbus_en seen while dbus_wait is high is dropped and flagged on err_drop.
interface dbus_mem_responder_if #(
    parameter int DMEM_WIDTH     = 128,
    parameter int DMEM_ADDRWIDTH = 32
);
    logic [DMEM_ADDRWIDTH-1:0] dbus_address;
    logic                      dbus_en;
    logic                      dbus_wren;
    logic [DMEM_WIDTH/8-1:0]   dbus_byteen;
    logic [DMEM_WIDTH-1:0]     dbus_writedata;
    logic                      dbus_prefetch;
    logic [DMEM_WIDTH-1:0]     dbus_readdata;
    logic                      dbus_wait;
    logic                      dbus_data_valid;
    logic                      err_drop;

    modport master (
        output dbus_address, dbus_en, dbus_wren, dbus_byteen, dbus_writedata, dbus_prefetch,
        input  dbus_readdata, dbus_wait, dbus_data_valid, err_drop
    );

    modport slave (
        input  dbus_address, dbus_en, dbus_wren, dbus_byteen, dbus_writedata, dbus_prefetch,
        output dbus_readdata, dbus_wait, dbus_data_valid, err_drop
    );
endinterface

// File: rtl/dbus_mem_responder.sv
// Memory-side dbus responder: word-addressed array serviced with fixed read/write latency.
// Optional next-word prefetch buffer enabled by defining DBUS_RESP_PREFETCH_EN.
module dbus_mem_responder #(
    parameter int DMEM_WIDTH     = 128,
    parameter int DMEM_ADDRWIDTH = 32,
    parameter int DEPTH_LOG2     = 10,
    parameter int RD_LATENCY     = 4,
    parameter int WR_LATENCY     = 2
) (
    input  logic       clk,
    input  logic       resetn,
    dbus_mem_responder_if.slave bus,
    output logic [1:0] o_dbg_state
);
    localparam int BYTES   = DMEM_WIDTH / 8;
    localparam int OFF_W   = $clog2(BYTES);
    localparam int IDX_W   = DEPTH_LOG2;
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int LAT_W   = $clog2(LAT_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_BUSY = 2'd1,
        S_WR_BUSY = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [LAT_W-1:0]      r_lat_cnt, w_lat_nxt;
    logic [DMEM_WIDTH-1:0] r_mem [DEPTH];
    logic [DMEM_WIDTH-1:0] r_hold;
    logic [DMEM_WIDTH-1:0] r_readdata;
    logic                  r_data_valid;
    logic                  r_err_drop;

    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_idle;
    logic                  w_req_rd;
    logic                  w_req_wr;
    logic                  w_rd_done;
    logic                  w_pf_hit;
    logic [DMEM_WIDTH-1:0] w_pf_rdata;

    // Byte-offset bits and bits above the array index are ignored: aligned, aliasing accesses.
    assign w_idx     = bus.dbus_address[IDX_W+OFF_W-1:OFF_W];
    assign w_idx_nxt = w_idx + IDX_W'(1);
    assign w_idle    = (r_state == S_IDLE);
    assign w_req_rd  = w_idle & bus.dbus_en & ~bus.dbus_wren;
    assign w_req_wr  = w_idle & bus.dbus_en &  bus.dbus_wren;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat_cnt;
        w_rd_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_rd && !w_pf_hit) begin
                    w_state_nxt = S_RD_BUSY;
                    w_lat_nxt   = LAT_W'(RD_LATENCY - 1);
                end else if (w_req_wr) begin
                    w_state_nxt = S_WR_BUSY;
                    w_lat_nxt   = LAT_W'(WR_LATENCY - 1);
                end
            end
            S_RD_BUSY: begin
                w_lat_nxt = r_lat_cnt - LAT_W'(1);
                if (r_lat_cnt == LAT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_rd_done   = 1'b1;
                end
            end
            S_WR_BUSY: begin
                w_lat_nxt = r_lat_cnt - LAT_W'(1);
                if (r_lat_cnt == LAT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_lat_nxt   = '0;
            end
        endcase
    end

    // Array is never reset; a write is committed on its request edge unless reset is asserted.
    always_ff @(posedge clk) begin
        if (resetn && w_req_wr) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.dbus_byteen[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.dbus_writedata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hold       <= '0;
            r_readdata   <= '0;
            r_data_valid <= 1'b0;
            r_err_drop   <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (w_req_rd) begin
                r_hold <= r_mem[w_idx];
            end
            if (w_rd_done) begin
                r_readdata   <= r_hold;
                r_data_valid <= 1'b1;
            end else if (w_pf_hit) begin
                r_readdata   <= w_pf_rdata;
                r_data_valid <= 1'b1;
            end
            if (bus.dbus_en && !w_idle) begin
                r_err_drop <= 1'b1;
            end
        end
    end

`ifdef DBUS_RESP_PREFETCH_EN
    logic [IDX_W-1:0]      r_pf_idx;
    logic [DMEM_WIDTH-1:0] r_pf_data;
    logic                  r_pf_valid;

    assign w_pf_hit   = w_req_rd & r_pf_valid & (w_idx == r_pf_idx);
    assign w_pf_rdata = r_pf_data;

    // Writes to the buffered word are merged so a later hit never returns stale bytes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pf_valid <= 1'b0;
            r_pf_idx   <= '0;
            r_pf_data  <= '0;
        end else if (w_req_rd && !w_pf_hit && bus.dbus_prefetch) begin
            r_pf_valid <= 1'b1;
            r_pf_idx   <= w_idx_nxt;
            r_pf_data  <= r_mem[w_idx_nxt];
        end else if (w_req_wr && r_pf_valid && (w_idx == r_pf_idx)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.dbus_byteen[b]) begin
                    r_pf_data[8*b +: 8] <= bus.dbus_writedata[8*b +: 8];
                end
            end
        end
    end
`else
    logic w_unused_pf;
    assign w_pf_hit    = 1'b0;
    assign w_pf_rdata  = '0;
    assign w_unused_pf = &{1'b0, w_idx_nxt, bus.dbus_prefetch};
`endif

    assign bus.dbus_readdata   = r_readdata;
    assign bus.dbus_wait       = ~w_idle;
    assign bus.dbus_data_valid = r_data_valid;
    assign bus.err_drop        = r_err_drop;
    assign o_dbg_state         = r_state;
endmodule
